qtree_update_ctrl: RTL and testbench

QTREE_UPDATE_CTRL -- requirements
Module: qtree_update_ctrl

---
 rtl/qtree_update_ctrl.sv | 237 +++++++++++++++++++++++
 tb/tb_qtree_update_ctrl.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/qtree_update_ctrl.sv
// qtree_update_ctrl -- batches host writes to the qtree control port and applies
// them atomically on commit_i, optionally draining in-flight lookups first.
//
// Optional feature macro: QTREE_UPD_DRAIN_EN
//   defined   : commit waits in DRAIN until every admitted lookup has returned
//               its result; lookups are held off while not IDLE.
//   undefined : no DRAIN state, no in-flight counter; commit goes straight to
//               WRITE, lookup_ready_o is constant 1, tree_result_valid_i unused.
//
// Ports:
//   clk_i, rst_i                         clock, synchronous active-high reset
//   wr_addr_i/wr_data_i/wr_valid_i       host write into the 8-entry buffer
//   wr_ready_o                           buffer accepts (IDLE and not full)
//   commit_i                             pulse: apply buffered writes
//   busy_o / done_o                      FSM not IDLE / commit finished pulse
//   lookup_valid_i / lookup_ready_o      user lookup handshake
//   tree_lookup_valid_o                  admitted lookup towards the tree
//   tree_result_valid_i                  lookup result back from the tree
//   mm_ctrl_addr_o/data_o/write_o        registered tree control write port

// Generic show-ahead FIFO: head entry visible combinationally on head_dat_o.
// Latency: a push is visible at the head the cycle after it is accepted.
// Backpressure: caller must not push when full_o or pop when empty_o.
module qtree_upd_fifo #(
  parameter int DW = 8,
  parameter int AW = 3
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          push_i,
  input  logic [DW-1:0] push_dat_i,
  input  logic          pop_i,
  output logic [DW-1:0] head_dat_o,
  output logic [AW:0]   count_o,
  output logic          full_o,
  output logic          empty_o
);
  localparam int            DEPTH   = 1 << AW;
  localparam logic [AW:0]   DEPTH_C = {1'b1, {AW{1'b0}}};
  localparam logic [AW-1:0] PTR_ONE = AW'(1);
  localparam logic [AW:0]   CNT_ONE = (AW+1)'(1);

  logic [DW-1:0] r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [AW:0]   r_count;

  // Storage needs no reset: only entries between the pointers are ever read.
  always_ff @(posedge clk_i) begin
    if (push_i) begin
      r_mem[r_wr_ptr] <= push_dat_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (push_i) r_wr_ptr <= r_wr_ptr + PTR_ONE;
      if (pop_i)  r_rd_ptr <= r_rd_ptr + PTR_ONE;
      case ({push_i, pop_i})
        2'b10:   r_count <= r_count + CNT_ONE;
        2'b01:   r_count <= r_count - CNT_ONE;
        default: r_count <= r_count;
      endcase
    end
  end

  assign head_dat_o = r_mem[r_rd_ptr];
  assign count_o    = r_count;
  assign full_o     = (r_count == DEPTH_C);
  assign empty_o    = (r_count == '0);
endmodule

// Commit controller: buffer host writes, on commit (optionally) drain lookups,
// then replay the buffer one entry per cycle onto the registered mm port.
// Latency: popped entry appears on mm_ctrl_* one cycle later; done_o aligns
// with the last write. Backpressure: wr_ready_o low outside IDLE or when full.
module qtree_update_ctrl #(
  parameter int MM_ADDR_WIDTH  = 16,
  parameter int MM_DATA_WIDTH  = 32,
  parameter int FIFO_AWIDTH    = 3,
  parameter int INFLIGHT_WIDTH = 6
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic [MM_ADDR_WIDTH-1:0] wr_addr_i,
  input  logic [MM_DATA_WIDTH-1:0] wr_data_i,
  input  logic                     wr_valid_i,
  output logic                     wr_ready_o,
  input  logic                     commit_i,
  output logic                     busy_o,
  output logic                     done_o,
  input  logic                     lookup_valid_i,
  output logic                     lookup_ready_o,
  output logic                     tree_lookup_valid_o,
  input  logic                     tree_result_valid_i,
  output logic [MM_ADDR_WIDTH-1:0] mm_ctrl_addr_o,
  output logic [MM_DATA_WIDTH-1:0] mm_ctrl_data_o,
  output logic                     mm_ctrl_write_o
);
  localparam int                 EW      = MM_ADDR_WIDTH + MM_DATA_WIDTH;
  localparam logic [FIFO_AWIDTH:0] CNT_ONE = (FIFO_AWIDTH+1)'(1);

`ifdef QTREE_UPD_DRAIN_EN
  typedef enum logic [1:0] {IDLE = 2'd0, DRAIN = 2'd1, WRITE = 2'd2} state_t;
  localparam state_t COMMIT_ST = DRAIN;
`else
  typedef enum logic [1:0] {IDLE = 2'd0, WRITE = 2'd2} state_t;
  localparam state_t COMMIT_ST = WRITE;
`endif

  state_t                  r_state;
  state_t                  w_state_nxt;
  logic                    w_push;
  logic                    w_pop;
  logic                    w_last;
  logic                    w_commit;
  logic                    w_full;
  logic                    w_empty;
  logic [FIFO_AWIDTH:0]    w_count;
  logic [EW-1:0]           w_head;
  logic                    r_done;
  logic                    r_mm_write;
  logic [MM_ADDR_WIDTH-1:0] r_mm_addr;
  logic [MM_DATA_WIDTH-1:0] r_mm_data;

  assign wr_ready_o = (r_state == IDLE) && !w_full;
  assign w_push     = wr_valid_i && wr_ready_o;
  assign w_commit   = commit_i && (r_state == IDLE);
  assign w_pop      = (r_state == WRITE) && !w_empty;
  assign w_last     = w_pop && (w_count == CNT_ONE);

  qtree_upd_fifo #(
    .DW (EW),
    .AW (FIFO_AWIDTH)
  ) u_fifo (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .push_i     (w_push),
    .push_dat_i ({wr_addr_i, wr_data_i}),
    .pop_i      (w_pop),
    .head_dat_o (w_head),
    .count_o    (w_count),
    .full_o     (w_full),
    .empty_o    (w_empty)
  );

`ifdef QTREE_UPD_DRAIN_EN
  localparam logic [INFLIGHT_WIDTH-1:0] INF_ONE = INFLIGHT_WIDTH'(1);
  localparam logic [INFLIGHT_WIDTH-1:0] INF_MAX = '1;

  logic [INFLIGHT_WIDTH-1:0] r_cnt;
  logic                      w_inc;
  logic                      w_dec;

  assign lookup_ready_o = (r_state == IDLE);
  assign w_inc          = tree_lookup_valid_o;
  assign w_dec          = tree_result_valid_i;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_cnt <= '0;
    end else begin
      case ({w_inc, w_dec})
        2'b10:   r_cnt <= r_cnt + INF_ONE;
        2'b01:   r_cnt <= r_cnt - INF_ONE;
        default: r_cnt <= r_cnt;
      endcase
    end
  end

`ifndef SYNTHESIS
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      assert (!(w_inc && !w_dec && (r_cnt == INF_MAX)));
      assert (!(w_dec && !w_inc && (r_cnt == '0)));
    end
  end
`endif
`else
  logic w_unused;
  assign lookup_ready_o = 1'b1;
  assign w_unused       = &{1'b0, tree_result_valid_i, INFLIGHT_WIDTH[0]};
`endif

  // A lookup in the commit cycle is still admitted: ready drops only once
  // the state register has left IDLE.
  assign tree_lookup_valid_o = lookup_valid_i && lookup_ready_o;

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE: begin
        // A push in the commit cycle joins the batch even if the FIFO was empty.
        if (w_commit && (!w_empty || w_push)) w_state_nxt = COMMIT_ST;
      end
`ifdef QTREE_UPD_DRAIN_EN
      DRAIN: begin
        if (r_cnt == '0) w_state_nxt = WRITE;
      end
`endif
      WRITE: begin
        if (w_last || w_empty) w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state    <= IDLE;
      r_done     <= 1'b0;
      r_mm_write <= 1'b0;
      r_mm_addr  <= '0;
      r_mm_data  <= '0;
    end else begin
      r_state    <= w_state_nxt;
      // Empty commit finishes immediately; otherwise done aligns with the
      // final registered write.
      r_done     <= (w_commit && w_empty && !w_push) || w_last;
      r_mm_write <= w_pop;
      if (w_pop) begin
        r_mm_addr <= w_head[EW-1:MM_DATA_WIDTH];
        r_mm_data <= w_head[MM_DATA_WIDTH-1:0];
      end
    end
  end

  assign busy_o          = (r_state != IDLE);
  assign done_o          = r_done;
  assign mm_ctrl_write_o = r_mm_write;
  assign mm_ctrl_addr_o  = r_mm_addr;
  assign mm_ctrl_data_o  = r_mm_data;
endmodule

// File: tb/tb_qtree_update_ctrl.sv
// Directed bench for qtree_update_ctrl; the same stimulus adapts to the
// QTREE_UPD_DRAIN_EN build through the expected commit-to-write latency.
module tb_qtree_update_ctrl;
  logic        clk_i = 1'b0;
  logic        rst_i;
  logic [15:0] wr_addr_i;
  logic [31:0] wr_data_i;
  logic        wr_valid_i;
  logic        wr_ready_o;
  logic        commit_i;
  logic        busy_o;
  logic        done_o;
  logic        lookup_valid_i;
  logic        lookup_ready_o;
  logic        tree_lookup_valid_o;
  logic        tree_result_valid_i;
  logic [15:0] mm_ctrl_addr_o;
  logic [31:0] mm_ctrl_data_o;
  logic        mm_ctrl_write_o;

  int n_chk  = 0;
  int n_fail = 0;

`ifdef QTREE_UPD_DRAIN_EN
  localparam int   LAT     = 2;     // commit edge -> DRAIN -> WRITE -> first write
  localparam logic LR_BUSY = 1'b0;  // lookups held off while busy
`else
  localparam int   LAT     = 1;     // commit edge -> WRITE -> first write
  localparam logic LR_BUSY = 1'b1;
`endif

  logic [15:0] ta [16];
  logic [31:0] td [16];

  qtree_update_ctrl dut (
    .clk_i               (clk_i),
    .rst_i               (rst_i),
    .wr_addr_i           (wr_addr_i),
    .wr_data_i           (wr_data_i),
    .wr_valid_i          (wr_valid_i),
    .wr_ready_o          (wr_ready_o),
    .commit_i            (commit_i),
    .busy_o              (busy_o),
    .done_o              (done_o),
    .lookup_valid_i      (lookup_valid_i),
    .lookup_ready_o      (lookup_ready_o),
    .tree_lookup_valid_o (tree_lookup_valid_o),
    .tree_result_valid_i (tree_result_valid_i),
    .mm_ctrl_addr_o      (mm_ctrl_addr_o),
    .mm_ctrl_data_o      (mm_ctrl_data_o),
    .mm_ctrl_write_o     (mm_ctrl_write_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one clock; outputs are then sampled 1 time unit after the edge.
  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic push(input int idx);
    wr_addr_i  = ta[idx];
    wr_data_i  = td[idx];
    wr_valid_i = 1'b1;
    tick();
    wr_valid_i = 1'b0;
  endtask

  task automatic commit();
    commit_i = 1'b1;
    tick();
    commit_i = 1'b0;
  endtask

  // Called right after the commit edge: expect n back-to-back writes of
  // entries base..base+n-1 starting lat edges later, done with the last.
  task automatic run_batch(input int base, input int n, input int lat);
    for (int k = 1; k <= lat + n; k++) begin
      tick();
      chk("mm_write", mm_ctrl_write_o, (k >= lat && k < lat + n));
      chk("done", done_o, (k == lat + n - 1));
      chk("busy", busy_o, (k < lat + n - 1));
      if (k >= lat && k < lat + n) begin
        chk("mm_addr", mm_ctrl_addr_o, ta[base + k - lat]);
        chk("mm_data", mm_ctrl_data_o, td[base + k - lat]);
      end
    end
    chk("addr_hold", mm_ctrl_addr_o, ta[base + n - 1]);
    chk("data_hold", mm_ctrl_data_o, td[base + n - 1]);
    chk("wr_ready_after", wr_ready_o, 1'b1);
    chk("lookup_ready_after", lookup_ready_o, 1'b1);
  endtask

  initial begin
    for (int i = 0; i < 16; i++) begin
      ta[i] = 16'hA000 + 16'(i * 16'h0111);
      td[i] = 32'hD000_0000 ^ (32'(i) * 32'h0101_0101);
    end
    rst_i = 1'b1; wr_addr_i = '0; wr_data_i = '0; wr_valid_i = 1'b0;
    commit_i = 1'b0; lookup_valid_i = 1'b0; tree_result_valid_i = 1'b0;
    tick(); tick();
    rst_i = 1'b0;

    // Reset state
    chk("rst_wr_ready", wr_ready_o, 1'b1);
    chk("rst_lookup_ready", lookup_ready_o, 1'b1);
    chk("rst_busy", busy_o, 1'b0);
    chk("rst_done", done_o, 1'b0);
    chk("rst_mm_write", mm_ctrl_write_o, 1'b0);
    chk("rst_mm_addr", mm_ctrl_addr_o, 16'h0);
    chk("rst_mm_data", mm_ctrl_data_o, 32'h0);

    // Three buffered writes replayed in order
    push(0); push(1); push(2);
    commit();
    chk("b3_busy", busy_o, 1'b1);
    chk("b3_wr_ready", wr_ready_o, 1'b0);
    chk("b3_lookup_ready", lookup_ready_o, LR_BUSY);
    lookup_valid_i = 1'b1; #1;
    chk("b3_tree_lookup", tree_lookup_valid_o, LR_BUSY);
    lookup_valid_i = 1'b0;
    run_batch(0, 3, LAT);

    // Empty commit: done next cycle, never busy, no write
    commit();
    chk("empty_done", done_o, 1'b1);
    chk("empty_busy", busy_o, 1'b0);
    chk("empty_mm_write", mm_ctrl_write_o, 1'b0);
    tick();
    chk("empty_done_pulse", done_o, 1'b0);
    chk("empty_mm_write2", mm_ctrl_write_o, 1'b0);

    // Write in the commit cycle joins the batch
    wr_addr_i = ta[3]; wr_data_i = td[3]; wr_valid_i = 1'b1;
    commit();
    wr_valid_i = 1'b0;
    chk("pc_busy", busy_o, 1'b1);
    chk("pc_done", done_o, 1'b0);
    run_batch(3, 1, LAT);

    // Fill to 8 entries, ninth write refused, then eight writes
    for (int i = 0; i < 8; i++) begin
      chk("fill_wr_ready", wr_ready_o, 1'b1);
      push(4 + i);
    end
    chk("full_wr_ready", wr_ready_o, 1'b0);
    wr_addr_i = ta[15]; wr_data_i = td[15]; wr_valid_i = 1'b1;
    tick();
    wr_valid_i = 1'b0;
    chk("full_wr_ready2", wr_ready_o, 1'b0);
    commit();
    run_batch(4, 8, LAT);

    // Lookup with a simultaneous result in IDLE
    lookup_valid_i = 1'b1; tree_result_valid_i = 1'b1; #1;
    chk("idle_tree_lookup", tree_lookup_valid_o, 1'b1);
    tick();
    lookup_valid_i = 1'b0; tree_result_valid_i = 1'b0;
    chk("idle_lookup_ready", lookup_ready_o, 1'b1);

`ifdef QTREE_UPD_DRAIN_EN
    // Four lookups in flight; commit cycle carries one lookup and one result
    push(0); push(1);
    lookup_valid_i = 1'b1;
    for (int i = 0; i < 4; i++) tick();
    tree_result_valid_i = 1'b1; commit_i = 1'b1; #1;
    chk("dr_commit_lookup", tree_lookup_valid_o, 1'b1);
    tick();
    commit_i = 1'b0; tree_result_valid_i = 1'b0;
    chk("dr_lookup_ready", lookup_ready_o, 1'b0);
    chk("dr_tree_lookup_blocked", tree_lookup_valid_o, 1'b0);
    lookup_valid_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("dr_wait_write", mm_ctrl_write_o, 1'b0);
      chk("dr_wait_busy", busy_o, 1'b1);
    end
    tree_result_valid_i = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("dr_ret_write", mm_ctrl_write_o, 1'b0);
    end
    tree_result_valid_i = 1'b0;
    run_batch(0, 2, 2);
`endif

    // Reset after two of five writes aborts the batch
    for (int i = 0; i < 5; i++) push(i);
    commit();
    for (int k = 1; k <= LAT + 1; k++) begin
      tick();
      chk("ab_write", mm_ctrl_write_o, (k >= LAT));
      if (k >= LAT) chk("ab_addr", mm_ctrl_addr_o, ta[k - LAT]);
    end
    rst_i = 1'b1;
    tick();
    rst_i = 1'b0;
    chk("ab_rst_write", mm_ctrl_write_o, 1'b0);
    chk("ab_rst_addr", mm_ctrl_addr_o, 16'h0);
    chk("ab_rst_busy", busy_o, 1'b0);
    chk("ab_rst_wr_ready", wr_ready_o, 1'b1);
    chk("ab_rst_lookup_ready", lookup_ready_o, 1'b1);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("ab_no_write", mm_ctrl_write_o, 1'b0);
    end
    commit();
    chk("ab_empty_done", done_o, 1'b1);
    chk("ab_empty_busy", busy_o, 1'b0);
    tick();
    chk("ab_empty_done_pulse", done_o, 1'b0);
    chk("ab_empty_write", mm_ctrl_write_o, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
